// File: rtl/csa16_wide_add_seq.sv
// csa16_wide_add_seq: NUM_WORDS x 16-bit add/subtract sequenced over one external 16-bit adder
// Ports:
//   clk, rst_n                - clock (rising edge), synchronous active-low reset
//   req_valid/req_ready       - request handshake; req_a, req_b, req_sub sampled on acceptance
//   rsp_valid/rsp_ready       - response handshake; rsp_sum, rsp_cout, rsp_ovf, rsp_zero
//   add_a, add_b, add_cin     - drive the shared adder (zero outside RUN)
//   add_sum, add_cout         - combinational result of the shared adder
module csa16_wide_add_seq #(
    parameter int NUM_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [16*NUM_WORDS-1:0]   req_a,
    input  logic [16*NUM_WORDS-1:0]   req_b,
    input  logic                      req_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [16*NUM_WORDS-1:0]   rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_ovf,
    output logic                      rsp_zero,
    output logic [15:0]               add_a,
    output logic [15:0]               add_b,
    output logic                      add_cin,
    input  logic [15:0]               add_sum,
    input  logic                      add_cout
);
    localparam int W  = 16 * NUM_WORDS;
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic          run;

    assign run       = state_q == RUN;
    assign add_a     = run ? a_q[16*idx_q +: 16] : '0;
    assign add_b     = run ? b_q[16*idx_q +: 16] : '0;
    // carry-in comes only from the registered carry, never straight from add_cout
    assign add_cin   = run & carry_q;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == DONE;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_zero  = zero_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (req_valid) begin
                // subtract as A + ~B + 1, the +1 entering as the initial carry
                a_d     = req_a;
                b_d     = req_sub ? ~req_b : req_b;
                carry_d = req_sub;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[16*idx_q +: 16] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[15] != a_q[W-1]);
                    // every lower slice has been rewritten by this operation already
                    zero_d  = (add_sum == '0) && (sum_q[W-17:0] == '0);
                    state_d = DONE;
                end
            end
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_csa16_wide_add_seq.sv
// tb_csa16_wide_add_seq: directed self-checking bench for csa16_wide_add_seq with a behavioural 16-bit adder
module tb_csa16_wide_add_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_sub;
    logic [63:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_ovf, rsp_zero;
    logic [63:0] rsp_sum;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  cins;
    logic [15:0] a0, b0;

    always #5 clk = ~clk;

    // stand-in for carry_select_adder16
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    csa16_wide_add_seq #(.NUM_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // called at a negedge with the DUT idle; returns at the first negedge of DONE
    task automatic start_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_sub = s;
        check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_a = '1;
        req_b = '1;
        req_sub = ~s;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cins[i] = add_cin;
            if (i == 0) begin
                a0 = add_a;
                b0 = add_b;
            end
            if (i == 3) check({tag, "_early_valid"}, {63'd0, rsp_valid}, 64'd0);
        end
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic finish_op;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [63:0] sum, input logic c, input logic o, input logic z);
        check({tag, "_sum"}, rsp_sum, sum);
        check({tag, "_cout"}, {63'd0, rsp_cout}, {63'd0, c});
        check({tag, "_ovf"}, {63'd0, rsp_ovf}, {63'd0, o});
        check({tag, "_zero"}, {63'd0, rsp_zero}, {63'd0, z});
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_sub = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_sum", rsp_sum, 64'd0);
        check("rst_flags", {61'd0, rsp_cout, rsp_ovf, rsp_zero}, 64'd0);
        check("rst_add", {31'd0, add_a, add_b, add_cin}, 64'd0);

        start_op("add", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        check("add_cins", {60'd0, cins}, 64'b0010);
        check("add_a0", {48'd0, a0}, 64'hFFFF);
        check("add_b0", {48'd0, b0}, 64'h0001);
        check_rsp("add", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        finish_op();

        start_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        check("wrap_cins", {60'd0, cins}, 64'b1110);
        check_rsp("wrap", 64'h0, 1'b1, 1'b0, 1'b1);
        finish_op();

        start_op("sub01", 64'h0, 64'h1, 1'b1);
        check("sub01_cins", {60'd0, cins}, 64'b0001);
        check_rsp("sub01", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        finish_op();

        start_op("sub55", 64'h5, 64'h5, 1'b1);
        check("sub55_b0", {48'd0, b0}, 64'hFFFA);
        check_rsp("sub55", 64'h0, 1'b1, 1'b0, 1'b1);
        finish_op();

        start_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        check_rsp("ovf_add", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        finish_op();

        start_op("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b1);
        check_rsp("ovf_sub", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        finish_op();

        // backpressure: a new request waits while the response is held
        start_op("bp", 64'h1234, 64'h1111, 1'b0);
        req_valid = 1'b1;
        req_a = 64'h10;
        req_b = 64'h20;
        req_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_hold_ready", {63'd0, req_ready}, 64'd0);
            check("bp_hold_sum", rsp_sum, 64'h2345);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_ready", {63'd0, req_ready}, 64'd1);
        check("bp_idle_valid", {63'd0, rsp_valid}, 64'd0);
        check("bp_persist", rsp_sum, 64'h2345);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_taken", {63'd0, req_ready}, 64'd0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("bp2_valid", {63'd0, rsp_valid}, 64'd1);
        check("bp2_sum", rsp_sum, 64'h30);
        finish_op();

        // reset while idx == 2 in RUN
        req_valid = 1'b1;
        req_a = 64'h0003_0002_0001_0009;
        req_b = 64'h0001_0001_0001_0001;
        req_sub = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_add_a", {48'd0, add_a}, 64'h0002);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid_sum", rsp_sum, 64'd0);
        check("mid_ready", {63'd0, req_ready}, 64'd1);
        check("mid_add", {31'd0, add_a, add_b, add_cin}, 64'd0);
        start_op("post", 64'h3, 64'h4, 1'b0);
        check_rsp("post", 64'h7, 1'b0, 1'b0, 1'b0);
        finish_op();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
